// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM audio transmit/receive pair: FSM state encoding
// and default counter width / timeout.
package pwm_pkg;

  localparam int unsigned CW_DEF      = 10;
  localparam int unsigned TIMEOUT_DEF = 1023;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_rx_edge.sv
// Input conditioning for pwm_audio_rx: 2-flop synchronizer, optional glitch filter
// (PWM_RX_GLITCH_FILTER_EN), and an edge register producing sin_s, rise and fall.
module pwm_rx_edge
`ifdef PWM_RX_GLITCH_FILTER_EN
  #(parameter int unsigned DEGLITCH = 2)
`endif
  (
  input  logic clk,
  input  logic rst,
  input  logic sin,
  output logic sin_s,
  output logic rise,
  output logic fall
);

  logic sync1, sync2, sin_q;

  // NOTE: non-blocking assignments make each flop sample the previous stage's old
  // value, so the chain really is two flops deep regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sin;
      sync2 <= sync1;
    end
  end

`ifdef PWM_RX_GLITCH_FILTER_EN
  localparam int unsigned GW = $clog2(DEGLITCH + 1);
  logic [GW-1:0] gcnt;

  // sin_s follows sync2 only after DEGLITCH consecutive cycles of disagreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      sin_s <= 1'b0;
      gcnt  <= '0;
    end else if (sync2 == sin_s) begin
      gcnt  <= '0;
    end else if (gcnt == GW'(DEGLITCH - 1)) begin
      sin_s <= sync2;
      gcnt  <= '0;
    end else begin
      gcnt  <= gcnt + GW'(1);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) sin_s <= 1'b0;
    else     sin_s <= sync2;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) sin_q <= 1'b0;
    else     sin_q <= sin_s;
  end

  assign rise = sin_s & ~sin_q;
  assign fall = ~sin_s & sin_q;

endmodule

// File: rtl/pwm_audio_rx.sv
// PWM receiver: measures high time and period of each complete frame on sin.
// Optional input glitch filter enabled by defining PWM_RX_GLITCH_FILTER_EN.
module pwm_audio_rx
  import pwm_pkg::*;
#(
  parameter int unsigned CW      = CW_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
`ifdef PWM_RX_GLITCH_FILTER_EN
  ,
  parameter int unsigned DEGLITCH = 2
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sin,
  output logic [CW-1:0] high_cnt,
  output logic [CW-1:0] period,
  output logic          sample_valid,
  output logic          timeout,
  output logic          active
);

  logic sin_s, rise, fall;

  pwm_rx_edge
`ifdef PWM_RX_GLITCH_FILTER_EN
    #(.DEGLITCH(DEGLITCH))
`endif
    u_edge (
    .clk  (clk),
    .rst  (rst),
    .sin  (sin),
    .sin_s(sin_s),
    .rise (rise),
    .fall (fall)
  );

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, hcnt, hcnt_nx, high_nx, period_nx;
  logic          sv_nx, to_nx;

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    hcnt_nx   = hcnt;
    high_nx   = high_cnt;
    period_nx = period;
    sv_nx     = 1'b0;
    to_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nx = HIGH;
          cnt_nx   = CW'(1);
          hcnt_nx  = CW'(1);
        end
      end
      HIGH: begin
        if (cnt == CW'(TIMEOUT)) begin
          to_nx    = 1'b1;
          state_nx = IDLE;
          cnt_nx   = '0;
          hcnt_nx  = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
          if (sin_s) hcnt_nx = hcnt + CW'(1);
          if (fall)  state_nx = LOW;
        end
      end
      LOW: begin
        // A closing rise takes priority over a coincident timeout.
        if (rise) begin
          period_nx = cnt;
          high_nx   = hcnt;
          sv_nx     = 1'b1;
          state_nx  = HIGH;
          cnt_nx    = CW'(1);
          hcnt_nx   = CW'(1);
        end else if (cnt == CW'(TIMEOUT)) begin
          to_nx    = 1'b1;
          state_nx = IDLE;
          cnt_nx   = '0;
          hcnt_nx  = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      hcnt         <= '0;
      high_cnt     <= '0;
      period       <= '0;
      sample_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      hcnt         <= hcnt_nx;
      high_cnt     <= high_nx;
      period       <= period_nx;
      sample_valid <= sv_nx;
      timeout      <= to_nx;
    end
  end

  assign active = (state != IDLE);

endmodule

// File: tb/tb_pwm_audio_rx.sv
// Directed self-checking bench for pwm_audio_rx; expected values are hand-derived
// (frame 7/33 -> high_cnt 7, period 40). Honours PWM_RX_GLITCH_FILTER_EN.
module tb_pwm_audio_rx;

  localparam int CW      = 10;
  localparam int TIMEOUT = 1023;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sin = 1'b0;
  logic [CW-1:0] high_cnt, period;
  logic          sample_valid, timeout, active;

  pwm_audio_rx #(.CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .sin         (sin),
    .high_cnt    (high_cnt),
    .period      (period),
    .sample_valid(sample_valid),
    .timeout     (timeout),
    .active      (active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int sv_cyc[$], sv_h[$], sv_p[$], to_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled on the falling edge, away from output updates.
  always @(negedge clk) begin
    if (sample_valid) begin
      sv_cyc.push_back(cyc);
      sv_h.push_back(int'(high_cnt));
      sv_p.push_back(int'(period));
    end
    if (timeout) to_cyc.push_back(cyc);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic drive(input logic v, input int n);
    sin = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    sv_cyc.delete(); sv_h.delete(); sv_p.delete(); to_cyc.delete();
  endtask

  initial begin
    // 1: reset state and idle input
    repeat (3) @(negedge clk);
    check("rst_high_cnt", high_cnt, 0);
    check("rst_period", period, 0);
    check("rst_sv", sample_valid, 0);
    check("rst_to", timeout, 0);
    check("rst_active", active, 0);
    rst = 1'b0;
    drive(0, 50);
    check("idle_active", active, 0);
    check("idle_high_cnt", high_cnt, 0);
    check("idle_sv_count", sv_h.size(), 0);
    check("idle_to_count", to_cyc.size(), 0);

    // 2: three 7/33 frames -> two reports, 40 cycles apart
    do_reset();
    repeat (3) begin drive(1, 7); drive(0, 33); end
    check("f3_sv_count", sv_h.size(), 2);
    check("f3_h0", qget(sv_h, 0), 7);
    check("f3_p0", qget(sv_p, 0), 40);
    check("f3_h1", qget(sv_h, 1), 7);
    check("f3_p1", qget(sv_p, 1), 40);
    check("f3_spacing", qget(sv_cyc, 1) - qget(sv_cyc, 0), 40);
    check("f3_active", active, 1);

    // 3: 7/33 then 20/20
    do_reset();
    drive(1, 7); drive(0, 33); drive(1, 20); drive(0, 20); drive(1, 3); drive(0, 10);
    check("mix_sv_count", sv_h.size(), 2);
    check("mix_h0", qget(sv_h, 0), 7);
    check("mix_p0", qget(sv_p, 0), 40);
    check("mix_h1", qget(sv_h, 1), 20);
    check("mix_p1", qget(sv_p, 1), 40);

    // 4: stuck-low timeout after a reported frame
    do_reset();
    drive(1, 7); drive(0, 33); drive(1, 7);
    check("tl_active_before", active, 1);
    drive(0, TIMEOUT + 20);
    check("tl_sv_count", sv_h.size(), 1);
    check("tl_to_count", to_cyc.size(), 1);
    check("tl_to_delay", qget(to_cyc, 0) - qget(sv_cyc, 0), TIMEOUT);
    check("tl_active_after", active, 0);
    check("tl_high_kept", high_cnt, 7);
    check("tl_period_kept", period, 40);

    // 5: stuck-high timeout, then re-sync
    do_reset();
    drive(1, TIMEOUT + 20);
    check("th_to_count", to_cyc.size(), 1);
    check("th_sv_count", sv_h.size(), 0);
    check("th_active", active, 0);
    drive(0, 33);
    drive(1, 7); drive(0, 33); drive(1, 7); drive(0, 33); drive(1, 3); drive(0, 5);
    check("rs_sv_count", sv_h.size(), 2);
    check("rs_h0", qget(sv_h, 0), 7);
    check("rs_p0", qget(sv_p, 0), 40);
    check("rs_to_count", to_cyc.size(), 1);

    // 6a: reset mid-HIGH clears outputs with no pulse
    do_reset();
    drive(1, 7); drive(0, 33); drive(1, 4);
    check("mr_high_before", high_cnt, 7);
    rst = 1'b1;
    @(negedge clk);
    check("mr_high_cnt", high_cnt, 0);
    check("mr_period", period, 0);
    check("mr_active", active, 0);
    check("mr_sv", sample_valid, 0);
    check("mr_to", timeout, 0);
    rst = 1'b0;
    drive(0, 5);
    check("mr_sv_count", sv_h.size(), 1);

    // 6b: one-cycle spike inside the low phase
    do_reset();
    drive(1, 7); drive(0, 10); drive(1, 1); drive(0, 22);
    drive(1, 7); drive(0, 33); drive(1, 3); drive(0, 5);
`ifdef PWM_RX_GLITCH_FILTER_EN
    check("gl_sv_count", sv_h.size(), 2);
    check("gl_h0", qget(sv_h, 0), 7);
    check("gl_p0", qget(sv_p, 0), 40);
    check("gl_h1", qget(sv_h, 1), 7);
    check("gl_p1", qget(sv_p, 1), 40);
`else
    check("gl_sv_count", sv_h.size(), 3);
    check("gl_h0", qget(sv_h, 0), 7);
    check("gl_p0", qget(sv_p, 0), 17);
    check("gl_h1", qget(sv_h, 1), 1);
    check("gl_p1", qget(sv_p, 1), 23);
    check("gl_h2", qget(sv_h, 2), 7);
    check("gl_p2", qget(sv_p, 2), 40);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
